risc_v_fetch_buf: RTL and testbench
===================================

RISC_V_FETCH_BUF -- requirements
Module: risc_v_fetch_buf

Interface
REQ-001 SHALL have parameters, one per line:
- XLEN, default 32, address and instruction width.
- DEPTH, default 4, instruction buffer entries; must be a power of 2 and at least 2.
- RESET_PC, default 0, PC loaded at reset.
REQ-002 SHALL have ports, one per line:
- clk, in, 1, clock.
- clrn, in, 1, reset; synchronous, active-low.
- imem_req_valid, out, 1, fetch request.
- imem_req_ready, in, 1, memory accepts request.
- imem_addr, out, XLEN, fetch address.
- imem_rsp_valid, in, 1, response strobe; responses are in order, one per accepted request.
- imem_rsp_data, in, XLEN, fetched instruction.
- redirect, in, 1, branch/jump taken.
- redirect_pc, in, XLEN, redirect target.
- inst_valid, out, 1, buffer head valid.
- inst_ready, in, 1, decode accepts head.
- inst_o, out, XLEN, head instruction.
- pc_o, out, XLEN, head PC.
- count_o, out, $clog2(DEPTH)+1, buffer occupancy.

Function
REQ-003 SHALL hold fetch PC (fpc), response PC (rpc), buffer count, in-flight counter (inflt) and discard counter (disc).
REQ-004 SHALL assert imem_req_valid when all of the following hold:
- !redirect
- count + (inflt - disc) < DEPTH
REQ-005 SHALL drive imem_addr = fpc.
REQ-006 SHALL treat a request as accepted when imem_req_valid && imem_req_ready; on acceptance, fpc += 4 (mod 2^XLEN wrap) and inflt += 1.
REQ-007 SHALL decrement inflt on every imem_rsp_valid; net change in a cycle with both accept and response = 0.
REQ-008 SHALL drop a response when disc != 0 (disc -= 1); otherwise SHALL write {rpc, imem_rsp_data} to the buffer tail and set rpc += 4.
REQ-009 SHALL pop the head when inst_valid && inst_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-010 SHALL drive inst_valid = (count != 0), except as REQ-020 extends it.
REQ-011 SHALL guarantee by REQ-004 crediting that the buffer never overflows; a live response into a full buffer is an assertion failure.
REQ-012 SHALL apply a redirect with priority over every other event in the same cycle:
- fpc, rpc <= redirect_pc
- count <= 0 and the head is not popped
- disc <= inflt after this cycle's response is accounted
- no request is issued
REQ-013 SHALL allow back-to-back redirects; each one reloads disc from the current inflt.
REQ-014 SHALL produce the first request the cycle after reset deassertion; minimum latency from response to inst_valid is 1 cycle.
REQ-015 SHALL hold imem_req_valid and imem_addr stable while imem_req_ready is low, unless a redirect occurs.

Reset
REQ-016 SHALL, when clrn=0 at posedge clk, set:
- fpc = rpc = RESET_PC
- count = inflt = disc = 0
- inst_valid = 0, imem_req_valid = 0
REQ-017 SHALL set inst_o and pc_o to 0 during reset.
REQ-018 SHALL discard all in-flight work on reset mid-operation; after reset the memory is assumed idle.
REQ-019 SHALL have no asynchronous reset paths.

Configuration
REQ-020 SHALL support macro RV_FETCH_BYPASS_EN:
- Defined: when count == 0 and a live response arrives, inst_valid, inst_o and pc_o SHALL be driven combinationally from that response in the same cycle. If inst_ready is also high, the response is consumed without being written.
- Undefined: every response passes through the buffer, with 1-cycle minimum latency.

Structure
REQ-021 SHALL place XLEN default, the ILEN_BYTES = 4 constant and a fetch_entry_t {pc, inst} typedef in shared package risc_v_pkg.
REQ-022 SHALL implement the buffer as sub-module risc_v_sync_fifo, parametrised by width and DEPTH, with wrap-around pointers and an extra count bit.

Verification
REQ-023 SHALL cover these directed scenarios:
- Reset: clrn held low 3 cycles, then released -> cycle 1 after release: imem_req_valid=1, imem_addr=0; inst_valid=0.
- Steady stream: 1-cycle memory, inst_ready=1 -> pc_o sequence 0, 4, 8, 12; one instruction per cycle after the first.
- Backpressure: DEPTH=4, inst_ready=0 -> exactly 4 requests issued; count_o=4; imem_req_valid stays 0 until one pop occurs.
- Redirect with 2 in flight: redirect_pc=0x100 -> both stale responses dropped; next pc_o=0x100 with the instruction fetched from 0x100.
- Redirect during a cycle with response, pop and imem_req_ready all high -> count_o=0 next cycle; no request that cycle; next imem_addr=redirect_pc.
- Wrap: RESET_PC=0xFFFFFFFC -> second imem_addr=0x00000000; pc_o wraps identically.

Source files
------------

// File: rtl/risc_v_pkg.sv
// risc_v_pkg: shared fetch-path constants and the buffered fetch entry type.
// No ports; imported by risc_v_sync_fifo and risc_v_fetch_buf.
package risc_v_pkg;
    localparam int XLEN       = 32;
    localparam int ILEN_BYTES = 4;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/risc_v_sync_fifo.sv
// risc_v_sync_fifo: synchronous FIFO with wrap-around pointers carrying an extra lap bit.
// Ports: clk, clrn (sync active-low reset), flush (empties the FIFO), push/din (write),
//        pop (read advance), dout (head entry), count (occupancy, 0..DEPTH).
module risc_v_sync_fifo
    import risc_v_pkg::*;
#(
    parameter int WIDTH = 2 * XLEN,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    always_ff @(posedge clk) begin
        if (!clrn || flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW+1)'(push);
            rp <= rp + (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push)
            mem[wp[AW-1:0]] <= din;
    end
    // The lap bit makes full (DEPTH) and empty (0) distinguishable.
    assign count = wp - rp;
    assign dout  = mem[rp[AW-1:0]];
    a_no_overflow: assert property (@(posedge clk) disable iff (!clrn || flush)
        !(push && count == (AW+1)'(DEPTH)));
endmodule

// File: rtl/risc_v_fetch_buf.sv
// risc_v_fetch_buf: credit-based instruction fetch unit with an in-order instruction buffer.
// Ports: clk, clrn (sync active-low reset);
//        imem_req_valid/imem_req_ready/imem_addr (fetch request channel);
//        imem_rsp_valid/imem_rsp_data (in-order responses, one per accepted request);
//        redirect/redirect_pc (branch/jump restart);
//        inst_valid/inst_ready/inst_o/pc_o (decode-side head), count_o (buffer occupancy).
// Option: define RV_FETCH_BYPASS_EN to present a live response to decode in the same
//         cycle when the buffer is empty.
module risc_v_fetch_buf
    import risc_v_pkg::*;
#(
    parameter int              XLEN     = risc_v_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    clrn,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_rsp_valid,
    input  logic [XLEN-1:0]         imem_rsp_data,
    input  logic                    redirect,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [XLEN-1:0]         inst_o,
    output logic [XLEN-1:0]         pc_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    // In-flight counters get headroom: back-to-back redirects can stack stale requests.
    localparam int IW = CW + 3;
    localparam logic [XLEN-1:0] STEP = XLEN'(ILEN_BYTES);

    logic [XLEN-1:0]   fpc, rpc;
    logic [IW-1:0]     inflt, disc;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] head;
    logic              accept, live, push, pop, bypass, credit_ok;

    // Live requests (inflt - disc) already own a buffer slot, so the buffer cannot overflow.
    assign credit_ok      = (IW'(count) + (inflt - disc)) < IW'(DEPTH);
    assign imem_req_valid = clrn && !redirect && credit_ok;
    assign imem_addr      = fpc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign live           = imem_rsp_valid && disc == '0;
`ifdef RV_FETCH_BYPASS_EN
    assign bypass = live && count == '0 && !redirect;
`else
    assign bypass = 1'b0;
`endif
    assign inst_valid = clrn && (count != '0 || bypass);
    assign inst_o     = !clrn ? '0 : bypass ? imem_rsp_data : head[XLEN-1:0];
    assign pc_o       = !clrn ? '0 : bypass ? rpc : head[2*XLEN-1:XLEN];
    assign pop        = clrn && !redirect && inst_ready && count != '0;
    // A bypassed response taken by decode this cycle never enters the buffer.
    assign push       = clrn && !redirect && live && !(bypass && inst_ready);
    assign count_o    = count;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            fpc   <= RESET_PC;
            rpc   <= RESET_PC;
            inflt <= '0;
            disc  <= '0;
        end else begin
            inflt <= inflt + IW'(accept) - IW'(imem_rsp_valid);
            if (redirect) begin
                fpc  <= redirect_pc;
                rpc  <= redirect_pc;
                // Everything still outstanding after this cycle's response is stale.
                disc <= inflt - IW'(imem_rsp_valid);
            end else begin
                if (accept)
                    fpc <= fpc + STEP;
                if (live)
                    rpc <= rpc + STEP;
                if (imem_rsp_valid && !live)
                    disc <= disc - IW'(1);
            end
        end
    end

    risc_v_sync_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .flush (redirect),
        .push  (push),
        .din   ({rpc, imem_rsp_data}),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );
endmodule

// File: tb/tb_risc_v_fetch_buf.sv
// tb_risc_v_fetch_buf: queue-based reference model plus directed scenarios for risc_v_fetch_buf.
module tb_risc_v_fetch_buf;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn, req_valid, req_ready, rsp_valid, redirect, inst_valid, inst_ready;
    logic [31:0] addr, rsp_data, redirect_pc, inst, pc;
    logic [2:0]  count;

    risc_v_fetch_buf #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .clrn(clrn),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst), .pc_o(pc),
        .count_o(count)
    );

    logic        w_clrn, w_req_valid, w_inst_valid, w_inst_ready;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_addr, w_inst, w_pc;
    logic [31:0] w_rsp_data = '0;
    logic [2:0]  w_count;

    risc_v_fetch_buf #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .clrn(w_clrn),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_addr(w_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect(1'b0), .redirect_pc(32'h0),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst_o(w_inst), .pc_o(w_pc),
        .count_o(w_count)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // Always-ready single-cycle memory for the wrap instance.
    always @(posedge clk) begin
        w_rsp_valid <= w_req_valid && w_clrn;
        w_rsp_data  <= inst_of(w_addr);
    end

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    ent_t        bufq[$];
    bit          stale_q[$];
    mreq_t       memq[$];
    logic [31:0] m_fpc, m_rpc;
    logic [31:0] popped_pc[$], popped_inst[$];
    int          cyc, tests, fails, mem_lat, acc;
    bit          mem_stall;
    logic        s_req_v, s_acc, s_pop, s_iv;
    logic [31:0] s_addr;
    logic [2:0]  s_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive memory response, compare DUT to model, advance model and memory.
    task automatic step();
        int   live_n;
        bit   e_live, e_byp, e_rv, e_iv;
        ent_t e_head;
        live_n = 0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        if (clrn && !mem_stall && memq.size() != 0 && memq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = inst_of(memq[0].addr);
        end
        #2;
        foreach (stale_q[i]) if (!stale_q[i]) live_n++;
        e_live = rsp_valid && stale_q.size() != 0 && !stale_q[0];
        e_byp  = 1'b0;
`ifdef RV_FETCH_BYPASS_EN
        e_byp  = e_live && bufq.size() == 0 && !redirect;
`endif
        e_rv = clrn && !redirect && (bufq.size() + live_n < DEPTH);
        e_iv = clrn && (bufq.size() != 0 || e_byp);
        if (e_byp) begin
            e_head.pc   = m_rpc;
            e_head.inst = rsp_data;
        end else if (bufq.size() != 0) begin
            e_head = bufq[0];
        end else begin
            e_head.pc   = '0;
            e_head.inst = '0;
        end
        chk("req_valid", 64'(req_valid), 64'(e_rv));
        chk("inst_valid", 64'(inst_valid), 64'(e_iv));
        if (!clrn) begin
            chk("pc_o_rst", 64'(pc), 64'(0));
            chk("inst_o_rst", 64'(inst), 64'(0));
        end else begin
            chk("imem_addr", 64'(addr), 64'(m_fpc));
            chk("count_o", 64'(count), 64'(bufq.size()));
            if (e_iv) begin
                chk("pc_o", 64'(pc), 64'(e_head.pc));
                chk("inst_o", 64'(inst), 64'(e_head.inst));
            end
        end
        s_req_v = req_valid;
        s_acc   = req_valid && req_ready;
        s_pop   = clrn && inst_valid && inst_ready && !redirect;
        s_iv    = inst_valid;
        s_addr  = addr;
        s_cnt   = count;
        if (s_pop) begin
            popped_pc.push_back(pc);
            popped_inst.push_back(inst);
        end
        if (!clrn) begin
            bufq.delete();
            stale_q.delete();
            memq.delete();
            m_fpc = '0;
            m_rpc = '0;
        end else begin
            if (rsp_valid && stale_q.size() != 0) void'(stale_q.pop_front());
            if (redirect) begin
                bufq.delete();
                foreach (stale_q[i]) stale_q[i] = 1'b1;
                m_fpc = redirect_pc;
                m_rpc = redirect_pc;
            end else begin
                if (e_rv && req_ready) begin
                    stale_q.push_back(1'b0);
                    m_fpc += 32'd4;
                end
                if (bufq.size() != 0 && inst_ready) void'(bufq.pop_front());
                if (e_live) begin
                    if (!(e_byp && inst_ready)) bufq.push_back('{m_rpc, rsp_data});
                    m_rpc += 32'd4;
                end
            end
            if (rsp_valid) void'(memq.pop_front());
            if (req_valid && req_ready) memq.push_back('{addr, cyc + mem_lat});
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset1();
        clrn = 1'b0;
        step();
        clrn = 1'b1;
    endtask

    task automatic wait_pop(input string name);
        int n;
        n = 0;
        popped_pc.delete();
        popped_inst.delete();
        while (popped_pc.size() == 0 && n < 12) begin
            step();
            n++;
        end
        chk({name, "_pop_seen"}, 64'(popped_pc.size() != 0), 64'(1));
        if (popped_pc.size() != 0) begin
            chk({name, "_pc"}, 64'(popped_pc[0]), 64'(redirect_pc));
            chk({name, "_inst"}, 64'(popped_inst[0]), 64'(inst_of(redirect_pc)));
        end
    endtask

    initial begin
        clrn = 1'b0; req_ready = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
        redirect_pc = '0; rsp_valid = 1'b0; rsp_data = '0;
        w_clrn = 1'b0; w_inst_ready = 1'b0;
        mem_stall = 1'b0; mem_lat = 1;
        tests = 0; fails = 0; cyc = 0;
        m_fpc = '0; m_rpc = '0;

        // Address and PC wrap with RESET_PC = 0xFFFFFFFC.
        repeat (3) @(negedge clk);
        w_clrn = 1'b1;
        #2;
        chk("wrap_req0", 64'(w_req_valid), 64'(1));
        chk("wrap_addr0", 64'(w_addr), 64'(32'hFFFF_FFFC));
        @(negedge clk); #2;
        chk("wrap_addr1", 64'(w_addr), 64'(32'h0));
        @(negedge clk); #2;
        chk("wrap_iv", 64'(w_inst_valid), 64'(1));
        chk("wrap_pc0", 64'(w_pc), 64'(32'hFFFF_FFFC));
        chk("wrap_inst0", 64'(w_inst), 64'(inst_of(32'hFFFF_FFFC)));
        w_inst_ready = 1'b1;
        @(negedge clk);
        w_inst_ready = 1'b0;
        #2;
        chk("wrap_pc1", 64'(w_pc), 64'(32'h0));
        chk("wrap_inst1", 64'(w_inst), 64'(inst_of(32'h0)));

        // Reset held 3 cycles, then first request on the first cycle after release.
        repeat (3) step();
        clrn = 1'b1; req_ready = 1'b1; inst_ready = 1'b1;
        popped_pc.delete();
        step();
        chk("rst_req_valid", 64'(s_req_v), 64'(1));
        chk("rst_addr", 64'(s_addr), 64'(0));
        chk("rst_inst_valid", 64'(s_iv), 64'(0));

        // Steady stream: one instruction per cycle starting two cycles after the first request.
        repeat (5) step();
        chk("stream_n", 64'(popped_pc.size()), 64'(4));
        if (popped_pc.size() >= 4)
            for (int i = 0; i < 4; i++) chk("stream_pc", 64'(popped_pc[i]), 64'(i * 4));

        // Backpressure fills exactly DEPTH entries.
        reset1();
        inst_ready = 1'b0;
        acc = 0;
        repeat (10) begin
            step();
            if (s_acc) acc++;
        end
        chk("bp_requests", 64'(acc), 64'(4));
        chk("bp_count", 64'(s_cnt), 64'(4));
        chk("bp_req_off", 64'(s_req_v), 64'(0));
        inst_ready = 1'b1;
        step();
        chk("bp_pop", 64'(s_pop), 64'(1));
        chk("bp_req_still_off", 64'(s_req_v), 64'(0));
        inst_ready = 1'b0;
        step();
        chk("bp_req_resume", 64'(s_req_v), 64'(1));
        chk("bp_count3", 64'(s_cnt), 64'(3));

        // Redirect with two requests in flight: both stale responses are dropped.
        reset1();
        mem_stall = 1'b1;
        repeat (2) step();
        req_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        chk("rd2_no_req", 64'(s_req_v), 64'(0));
        redirect = 1'b0; req_ready = 1'b1; mem_stall = 1'b0; inst_ready = 1'b1;
        wait_pop("rd2");

        // Redirect while a response, a pop and a ready request coincide.
        repeat (4) step();
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        chk("rdall_iv", 64'(s_iv), 64'(1));
        chk("rdall_no_req", 64'(s_req_v), 64'(0));
        redirect = 1'b0;
        step();
        chk("rdall_count", 64'(s_cnt), 64'(0));
        chk("rdall_addr", 64'(s_addr), 64'(32'h200));
        wait_pop("rdall");

        // Mixed traffic: stalls, variable latency, redirects and a mid-run reset.
        for (int i = 0; i < 300; i++) begin
            req_ready   = (i % 5) != 1;
            inst_ready  = (i % 7) < 4;
            mem_stall   = (i % 11) == 3;
            mem_lat     = 1 + (i % 3);
            redirect    = (i % 37) == 20;
            redirect_pc = 32'h1000 + 32'(i) * 32'd16;
            clrn        = i != 150;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
